// File: rtl/word_stream_mux.sv
// word_stream_mux: captures a bank of CHANNELS words and streams a run of
// them out one word per valid/ready beat, with wrap-around indexing.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_bus          flattened input words, word k = in_bus[k*WIDTH +: WIDTH]
//   start           stream request, sampled only while idle
//   start_idx       index of the first word
//   count           words to emit (0..CHANNELS, larger values clip)
//   stride          index step per beat (honoured only with the macro below)
//   out_data        registered output word
//   out_valid       out_data valid
//   out_ready       consumer ready
//   out_last        marks the final word of a stream
//   busy            a stream is in progress
//   done            one-cycle pulse after a stream completes
//
// Build option: define WORD_STREAM_MUX_STRIDE_EN to honour the stride port;
// without it the index always advances by one.

module word_stream_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic                      start,
    input  logic [SEL_W-1:0]          start_idx,
    input  logic [SEL_W:0]            count,
    input  logic [SEL_W-1:0]          stride,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [SEL_W:0] CH_CNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W:0] ONE    = (SEL_W+1)'(1);
    localparam logic [SEL_W:0] TWO    = (SEL_W+1)'(2);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W:0]   rem_q, rem_d;
    logic [SEL_W-1:0] stride_q, stride_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             load;

    logic [WIDTH-1:0] bank_q [CHANNELS];
    logic [WIDTH-1:0] in_words [CHANNELS];

    logic [SEL_W-1:0] stride_in;
    logic [SEL_W-1:0] idx_nxt;
    logic [SEL_W:0]   cnt_clip;
    logic             fire;

`ifdef WORD_STREAM_MUX_STRIDE_EN
    assign stride_in = stride;
`else
    assign stride_in = SEL_W'(1);
    logic unused_stride;
    assign unused_stride = ^stride;
`endif

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            in_words[k] = in_bus[k*WIDTH +: WIDTH];
        end
    end

    assign cnt_clip = (count > CH_CNT) ? CH_CNT : count;
    assign fire     = valid_q & out_ready;
    // Index arithmetic wraps naturally at SEL_W bits (CHANNELS is 2^SEL_W).
    assign idx_nxt  = idx_q + stride_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        stride_d = stride_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        load     = 1'b1;
                        state_d  = S_STREAM;
                        idx_d    = start_idx;
                        rem_d    = cnt_clip;
                        stride_d = stride_in;
                        data_d   = in_words[start_idx];
                        valid_d  = 1'b1;
                        last_d   = (cnt_clip == ONE);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (fire) begin
                    if (rem_q == ONE) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Pre-fetch the next word so out_data stays registered.
                        idx_d  = idx_nxt;
                        rem_d  = rem_q - ONE;
                        data_d = bank_q[idx_nxt];
                        last_d = (rem_q == TWO);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rem_q    <= '0;
            stride_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            stride_q <= stride_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    // Bank is pure storage; its contents only matter after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            bank_q <= in_words;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_STREAM);
    assign done      = done_q;

endmodule

// File: tb/tb_word_stream_mux.sv
// tb_word_stream_mux: scoreboard bench for word_stream_mux.
// Directed cases plus randomized streams against a queue-based model.

module tb_word_stream_mux;

    localparam int W  = 16;
    localparam int CH = 16;

`ifdef WORD_STREAM_MUX_STRIDE_EN
    localparam bit STR_EN = 1'b1;
`else
    localparam bit STR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH*W-1:0] in_bus = '0;
    logic          start = 1'b0;
    logic [3:0]    start_idx = '0;
    logic [4:0]    count = '0;
    logic [3:0]    stride = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    word_stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .stride    (stride),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] words [CH];
    int           n_checks = 0;
    int           n_fail = 0;
    logic         pend_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic load_bus(input bit pattern);
        for (int k = 0; k < CH; k++) begin
            words[k] = pattern ? W'(16'h1000 + k) : W'($urandom);
            in_bus[k*W +: W] = words[k];
        end
    endtask

    // Reference: n = min(count, CH) words at (idx + i*step) mod CH.
    task automatic model(input int sidx, input int cnt, input int strd);
        int n;
        int s;
        beat_t b;
        n = (cnt > CH) ? CH : cnt;
        s = STR_EN ? strd : 1;
        for (int i = 0; i < n; i++) begin
            b.d = words[(sidx + i * s) % CH];
            b.l = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: compares presented beats against the scoreboard head.
    always @(negedge clk) begin
        logic nxt;
        beat_t b;
        if (rst) begin
            pend_done = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(pend_done));
            nxt = start && (count == 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("data", 32'(out_data), 32'(exp_q[0].d));
                    chk("last", 32'(out_last), 32'(exp_q[0].l));
                    if (out_ready) begin
                        b = exp_q.pop_front();
                        if (b.l) nxt = 1'b1;
                    end
                end
            end
            pend_done = nxt;
        end
    end

    // mode 0: ready high; 1: ready low cycles 3..5; 2: random ready;
    // 3: ready high with a spurious start mid-stream.
    task automatic run(input int sidx, input int cnt, input int strd,
                       input int mode);
        int n;
        int cyc;
        n = (cnt > CH) ? CH : cnt;
        model(sidx, cnt, strd);
        start     = 1'b1;
        start_idx = 4'(sidx);
        count     = 5'(cnt);
        stride    = 4'(strd);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        load_bus(1'b0);
        if (n != 0) begin
            chk("first_valid", 32'(out_valid), 32'd1);
            chk("first_busy", 32'(busy), 32'd1);
        end else begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_valid", 32'(out_valid), 32'd0);
        end
        while (!done && cyc < 300) begin
            case (mode)
                1: out_ready = !(cyc >= 3 && cyc <= 5);
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && cyc == 5) begin
                start     = 1'b1;
                start_idx = 4'($urandom);
                count     = 5'($urandom_range(1, 20));
                stride    = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 300) chk("timeout", 32'(done), 32'd1);
        if (mode == 0 || mode == 3) chk("cycles", 32'(cyc), 32'(n + 1));
        if (mode == 1) chk("stall_cycles", 32'(cyc), 32'(n + 4));
        chk("busy_after", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        load_bus(1'b1); run(0, 16, 1, 0);
        load_bus(1'b1); run(0, 16, 1, 1);
        load_bus(1'b1); run(14, 4, 1, 0);
        load_bus(1'b1); run(1, 4, 4, 0);

        // Reset mid-stream after the fifth beat.
        load_bus(1'b1);
        model(0, 16, 1);
        start = 1'b1; start_idx = 4'd0; count = 5'd16; stride = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_sb", 32'(exp_q.size()), 32'd11);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        load_bus(1'b1); run(3, 2, 1, 0);

        load_bus(1'b1); run(5, 0, 1, 0);
        load_bus(1'b1); run(2, 20, 3, 3);

        for (int i = 0; i < 30; i++) begin
            load_bus(1'b0);
            run($urandom_range(0, 15), $urandom_range(0, 20),
                $urandom_range(0, 15), ($urandom_range(0, 1) != 0) ? 2 : 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
